// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: opcodes, forwarding-select encoding
// and the pipeline-sequencer state enum.
package rv32_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IMM   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
    localparam logic [OP_W-1:0] OP_BR    = 7'b1100011;

    localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EX = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } pipe_state_e;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Combinational source-register decode, operand-forwarding selects and
// load-use hazard detection for one decode slot.
module pipe_hazard_cmp
    import rv32_pkg::*;
(
    input  logic             dec_valid,
    input  logic [31:0]      dec_ins,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_w_en,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_w_en,
    output logic [FWD_W-1:0] fwd1_c,
    output logic [FWD_W-1:0] fwd2_c,
    output logic             load_use_c
);

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic             unused_ins;

    assign op  = dec_ins[6:0];
    assign rs1 = dec_ins[19:15];
    assign rs2 = dec_ins[24:20];
    assign unused_ins = ^{dec_ins[31:25], dec_ins[14:7]};

    assign use_rs1 = !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    assign use_rs2 = (op == OP_R) || (op == OP_STORE) || (op == OP_BR);

    // A load result is not ready in execute, so only ALU results forward from there.
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             ex_v,
        input logic             ex_w,
        input logic             ex_ld,
        input logic [REG_W-1:0] ex_d,
        input logic             wb_w,
        input logic [REG_W-1:0] wb_d
    );
        if (rs == '0)                          return FWD_RF;
        if (ex_v && ex_w && !ex_ld && ex_d == rs) return FWD_EX;
        if (wb_w && wb_d == rs)                return FWD_WB;
        return FWD_RF;
    endfunction

    assign fwd1_c = fwd_sel(rs1, ex_valid, ex_reg_w_en, ex_is_load, ex_rd, wb_reg_w_en, wb_rd);
    assign fwd2_c = fwd_sel(rs2, ex_valid, ex_reg_w_en, ex_is_load, ex_rd, wb_reg_w_en, wb_rd);

    assign load_use_c = dec_valid && ex_valid && ex_is_load && ex_reg_w_en
                        && (ex_rd != '0)
                        && ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// RV32 pipeline sequencer: stage enables, bubble/flush, forwarding selects,
// saturating stall counter and sticky memory-timeout flag.
module pipe_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [31:0]      dec_ins,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_w_en,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_w_en,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             dec_en,
    output logic             ex_en,
    output logic             ex_bubble,
    output logic             dec_flush,
    output logic [FWD_W-1:0] fwd1,
    output logic [FWD_W-1:0] fwd2,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned CW = 3;
    localparam int unsigned TW = 16;
    localparam logic [CW-1:0] LD_INIT = (LOAD_LAT > 1)     ? CW'(LOAD_LAT - 2)     : '0;
    localparam logic [CW-1:0] FL_INIT = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;
    localparam logic [TW-1:0] TMO     = TW'(MEM_TIMEOUT);

    pipe_state_e      state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic             err_set;
    logic [FWD_W-1:0] fwd1_c, fwd2_c;
    logic             load_use_c;

    pipe_hazard_cmp u_hazard (
        .dec_valid   (dec_valid),
        .dec_ins     (dec_ins),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_reg_w_en (ex_reg_w_en),
        .ex_is_load  (ex_is_load),
        .wb_rd       (wb_rd),
        .wb_reg_w_en (wb_reg_w_en),
        .fwd1_c      (fwd1_c),
        .fwd2_c      (fwd2_c),
        .load_use_c  (load_use_c)
    );

    // State, counters and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            tcnt      <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tcnt  <= tcnt_nxt;
            if (err_set) begin
                mem_err <= 1'b1;
            end
            if ((!pc_en || ex_bubble) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and all pipeline controls, combinational from state and inputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tcnt_nxt  = tcnt;
        err_set   = 1'b0;
        pc_en     = 1'b1;
        dec_en    = 1'b1;
        ex_en     = 1'b1;
        ex_bubble = 1'b0;
        dec_flush = 1'b0;
        fwd1      = fwd1_c;
        fwd2      = fwd2_c;

        unique case (state)
            ST_RUN: begin
                if (br_taken) begin
                    dec_flush = 1'b1;
                    ex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = FL_INIT;
                    end
                end else if (mem_req && !mem_ack) begin
                    pc_en     = 1'b0;
                    dec_en    = 1'b0;
                    ex_en     = 1'b0;
                    tcnt_nxt  = TW'(1);
                    state_nxt = ST_MEM_WAIT;
                end else if (load_use_c) begin
                    pc_en     = 1'b0;
                    dec_en    = 1'b0;
                    ex_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nxt = ST_LD_STALL;
                        cnt_nxt   = LD_INIT;
                    end
                end
            end
            ST_LD_STALL: begin
                pc_en     = 1'b0;
                dec_en    = 1'b0;
                ex_bubble = 1'b1;
                if (cnt == '0) state_nxt = ST_RUN;
                else           cnt_nxt   = cnt - CW'(1);
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    tcnt_nxt  = '0;
                    state_nxt = ST_RUN;
                end else if (tcnt == TMO) begin
                    // Abort: push a bubble into execute and hold the front end.
                    pc_en     = 1'b0;
                    dec_en    = 1'b0;
                    ex_bubble = 1'b1;
                    err_set   = 1'b1;
                    tcnt_nxt  = '0;
                    state_nxt = ST_RUN;
                end else begin
                    pc_en    = 1'b0;
                    dec_en   = 1'b0;
                    ex_en    = 1'b0;
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            ST_FLUSH: begin
                dec_flush = 1'b1;
                ex_bubble = 1'b1;
                if (cnt == '0) state_nxt = ST_RUN;
                else           cnt_nxt   = cnt - CW'(1);
            end
            default: state_nxt = ST_RUN;
        endcase

        if (rst) begin
            pc_en     = 1'b0;
            dec_en    = 1'b0;
            ex_en     = 1'b1;
            ex_bubble = 1'b1;
            dec_flush = 1'b1;
            fwd1      = FWD_RF;
            fwd2      = FWD_RF;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: instance a uses LOAD_LAT=2/FLUSH=2/TMO=255/CNT_W=16,
// instance b uses LOAD_LAT=1/FLUSH=1/TMO=4/CNT_W=4; both share the stimulus.
module tb_pipe_ctrl;

    localparam logic [31:0] ADD_1_2   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] ADD_0_0   = 32'h000001B3; // add x3,x0,x0
    localparam logic [31:0] SUB_5_7   = 32'h40728333; // sub x6,x5,x7
    localparam logic [31:0] SUB_0_7   = 32'h40700333; // sub x6,x0,x7
    localparam logic [31:0] LUI_RS5   = 32'h00028337; // lui with rs1 field = 5
    localparam logic [31:0] ADDI_RS25 = 32'h00508313; // addi x6,x1,5 (rs2 field = 5)
    localparam logic [31:0] SW_5      = 32'h00512023; // sw x5,0(x2)

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [31:0] dec_ins;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_w_en;
    logic        ex_is_load;
    logic [4:0]  wb_rd;
    logic        wb_reg_w_en;
    logic        br_taken;
    logic        mem_req;
    logic        mem_ack;

    logic        pc_en_a, dec_en_a, ex_en_a, ex_bubble_a, dec_flush_a, mem_err_a;
    logic [1:0]  fwd1_a, fwd2_a;
    logic [15:0] stall_cnt_a;
    logic        pc_en_b, dec_en_b, ex_en_b, ex_bubble_b, dec_flush_b, mem_err_b;
    logic [1:0]  fwd1_b, fwd2_b;
    logic [3:0]  stall_cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int exp_a = 0;
    int exp_b = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.LOAD_LAT(2), .FLUSH_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ins(dec_ins),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_w_en(ex_reg_w_en), .ex_is_load(ex_is_load),
        .wb_rd(wb_rd), .wb_reg_w_en(wb_reg_w_en), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en_a), .dec_en(dec_en_a), .ex_en(ex_en_a), .ex_bubble(ex_bubble_a),
        .dec_flush(dec_flush_a), .fwd1(fwd1_a), .fwd2(fwd2_a),
        .mem_err(mem_err_a), .stall_cnt(stall_cnt_a)
    );

    pipe_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ins(dec_ins),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_w_en(ex_reg_w_en), .ex_is_load(ex_is_load),
        .wb_rd(wb_rd), .wb_reg_w_en(wb_reg_w_en), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en_b), .dec_en(dec_en_b), .ex_en(ex_en_b), .ex_bubble(ex_bubble_b),
        .dec_flush(dec_flush_b), .fwd1(fwd1_b), .fwd2(fwd2_b),
        .mem_err(mem_err_b), .stall_cnt(stall_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_ins = 32'h0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_reg_w_en = 1'b0; ex_is_load = 1'b0;
        wb_rd = 5'd0; wb_reg_w_en = 1'b0;
        br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic load_in_ex(input logic [31:0] ins, input logic [4:0] rd);
        idle();
        dec_valid = 1'b1; dec_ins = ins;
        ex_valid = 1'b1; ex_reg_w_en = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
    endtask

    initial begin
        // Reset: controls forced even with a live forwarding match
        idle();
        rst = 1'b1;
        dec_valid = 1'b1; dec_ins = ADD_1_2;
        ex_valid = 1'b1; ex_reg_w_en = 1'b1; ex_rd = 5'd1;
        step(); step();
        check("rst_pc_en", 32'(pc_en_a), 0);
        check("rst_dec_en", 32'(dec_en_a), 0);
        check("rst_ex_en", 32'(ex_en_a), 1);
        check("rst_ex_bubble", 32'(ex_bubble_a), 1);
        check("rst_dec_flush", 32'(dec_flush_a), 1);
        check("rst_fwd1", 32'(fwd1_a), 0);
        check("rst_stall_cnt", 32'(stall_cnt_a), 0);
        check("rst_mem_err", 32'(mem_err_b), 0);

        // Forwarding patterns
        rst = 1'b0;
        idle();
        dec_valid = 1'b1; dec_ins = ADD_1_2;
        ex_valid = 1'b1; ex_reg_w_en = 1'b1; ex_rd = 5'd1;
        wb_reg_w_en = 1'b1; wb_rd = 5'd2;
        #1;
        check("fwd_ex_rs1", 32'(fwd1_a), 1);
        check("fwd_wb_rs2", 32'(fwd2_a), 2);
        check("fwd_no_stall", 32'(pc_en_a), 1);
        check("fwd_no_bubble", 32'(ex_bubble_a), 0);
        step();
        check("fwd_stall_cnt", 32'(stall_cnt_a), 0);
        wb_rd = 5'd1;
        #1;
        check("fwd_ex_prio", 32'(fwd1_a), 1);
        check("fwd_rs2_none", 32'(fwd2_a), 0);
        dec_valid = 1'b0; ex_is_load = 1'b1;
        #1;
        check("fwd_load_skips_ex", 32'(fwd1_b), 2);
        dec_ins = ADD_0_0; ex_is_load = 1'b0; ex_rd = 5'd0; wb_rd = 5'd0;
        #1;
        check("fwd_x0_rs1", 32'(fwd1_a), 0);
        check("fwd_x0_rs2", 32'(fwd2_a), 0);
        step();

        // Load-use on rs1: a stalls 2 cycles, b stalls 1
        load_in_ex(SUB_5_7, 5'd5);
        #1;
        check("lu0_pc_en", 32'(pc_en_a), 0);
        check("lu0_dec_en", 32'(dec_en_a), 0);
        check("lu0_ex_bubble", 32'(ex_bubble_a), 1);
        check("lu0_ex_en", 32'(ex_en_a), 1);
        step();
        ex_valid = 1'b0;
        #1;
        check("lu1_pc_en", 32'(pc_en_a), 0);
        check("lu1_ex_bubble", 32'(ex_bubble_a), 1);
        check("lu1_b_pc_en", 32'(pc_en_b), 1);
        step();
        idle();
        #1;
        check("lu2_pc_en", 32'(pc_en_a), 1);
        check("lu2_ex_bubble", 32'(ex_bubble_a), 0);
        exp_a += 2; exp_b += 1;
        check("lu_stall_cnt_a", 32'(stall_cnt_a), exp_a);
        check("lu_stall_cnt_b", 32'(stall_cnt_b), exp_b);
        step();

        // Cases that must not stall
        load_in_ex(SUB_0_7, 5'd0);
        #1;
        check("nolu_x0", 32'(pc_en_a), 1);
        load_in_ex(LUI_RS5, 5'd5);
        #1;
        check("nolu_lui", 32'(pc_en_a), 1);
        load_in_ex(ADDI_RS25, 5'd5);
        #1;
        check("nolu_imm_rs2", 32'(pc_en_a), 1);
        step();
        check("nolu_stall_cnt", 32'(stall_cnt_a), exp_a);

        // Load-use through rs2 of a store
        load_in_ex(SW_5, 5'd5);
        #1;
        check("lusw0_pc_en", 32'(pc_en_a), 0);
        step();
        ex_valid = 1'b0;
        #1;
        check("lusw1_pc_en", 32'(pc_en_a), 0);
        step();
        idle();
        exp_a += 2; exp_b += 1;
        #1;
        check("lusw_stall_cnt_a", 32'(stall_cnt_a), exp_a);

        // Branch beats mem_req and load_use in the same cycle
        load_in_ex(SUB_5_7, 5'd5);
        br_taken = 1'b1; mem_req = 1'b1;
        #1;
        check("br0_dec_flush", 32'(dec_flush_a), 1);
        check("br0_ex_bubble", 32'(ex_bubble_a), 1);
        check("br0_pc_en", 32'(pc_en_a), 1);
        check("br0_ex_en", 32'(ex_en_a), 1);
        step();
        br_taken = 1'b0; mem_req = 1'b0;
        #1;
        check("br1_dec_flush", 32'(dec_flush_a), 1);
        check("br1_dec_en", 32'(dec_en_a), 1);
        check("br1_b_dec_flush", 32'(dec_flush_b), 0);
        check("br1_b_pc_en", 32'(pc_en_b), 0);
        step();
        idle();
        #1;
        check("br2_dec_flush", 32'(dec_flush_a), 0);
        exp_a += 2; exp_b += 2;
        check("br_stall_cnt_a", 32'(stall_cnt_a), exp_a);
        check("br_stall_cnt_b", 32'(stall_cnt_b), exp_b);
        step();

        // Memory wait: a acks on the 6th cycle, b times out after tcnt reaches 4
        mem_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("mw%0d_en", k), 32'({pc_en_a, dec_en_a, ex_en_a, ex_bubble_a}), 0);
            if (k == 4) begin
                check("tmo_b_ex_en", 32'(ex_en_b), 1);
                check("tmo_b_ex_bubble", 32'(ex_bubble_b), 1);
                check("tmo_b_pc_en", 32'(pc_en_b), 0);
            end else begin
                check($sformatf("mw%0d_b_ex_en", k), 32'(ex_en_b), 0);
            end
            step();
        end
        mem_ack = 1'b1;
        #1;
        check("mw_release", 32'({pc_en_a, dec_en_a, ex_en_a, ex_bubble_a}), 4'b1110);
        check("mw_b_run_ack", 32'(pc_en_b), 1);
        check("mw_b_err_set", 32'(mem_err_b), 1);
        step();
        idle();
        exp_a += 5; exp_b += 5;
        #1;
        check("mw_err_a", 32'(mem_err_a), 0);
        check("mw_stall_cnt_a", 32'(stall_cnt_a), exp_a);
        check("mw_stall_cnt_b", 32'(stall_cnt_b), exp_b);
        step(); step(); step();
        check("err_sticky_b", 32'(mem_err_b), 1);

        // Reset during LD_STALL
        load_in_ex(SUB_5_7, 5'd5);
        step();
        rst = 1'b1;
        #1;
        check("rstld_pc_en", 32'(pc_en_a), 0);
        check("rstld_dec_flush", 32'(dec_flush_a), 1);
        step();
        rst = 1'b0;
        idle();
        #1;
        check("rstld_run_pc_en", 32'(pc_en_a), 1);
        check("rstld_run_bubble", 32'(ex_bubble_a), 0);
        check("rstld_stall_cnt", 32'(stall_cnt_a), 0);
        check("rstld_err_b", 32'(mem_err_b), 0);
        step();

        // Reset during MEM_WAIT
        mem_req = 1'b1;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        check("rstmw_en", 32'({pc_en_a, dec_en_a, ex_en_a}), 3'b111);
        check("rstmw_stall_cnt", 32'(stall_cnt_a), 0);
        check("rstmw_err_a", 32'(mem_err_a), 0);
        check("rstmw_err_b", 32'(mem_err_b), 0);

        // Continuous load-use: b saturates at 15, a keeps counting
        load_in_ex(SUB_5_7, 5'd5);
        repeat (15) step();
        check("sat15_b", 32'(stall_cnt_b), 15);
        check("sat15_a", 32'(stall_cnt_a), 15);
        repeat (5) step();
        check("sat20_b", 32'(stall_cnt_b), 15);
        check("sat20_a", 32'(stall_cnt_a), 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
